// File: rtl/pixel_req_pkg.sv
// ----------------------------------------------------------------------------
// pixel_req_pkg
// Shared definitions for the pixel event requester.
//   addr_w()      : pixel address width for a given pixel count
//   pixel_pkt_t   : {addr, count} readout packet for the default 256 x 4 setup
// ----------------------------------------------------------------------------
package pixel_req_pkg;

   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

   localparam int NUM_REQUESTS_DEF = 256;
   localparam int CNT_W_DEF        = 4;
   localparam int ADDR_W_DEF       = addr_w(NUM_REQUESTS_DEF);

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [CNT_W_DEF-1:0]  count;
   } pixel_pkt_t;

endpackage

// File: rtl/pixel_gnt_encoder.sv
// ----------------------------------------------------------------------------
// pixel_gnt_encoder
// Combinational one-hot to binary encoder with grant sanity flags.
//   gnt_i   : grant vector, expected one-hot or zero
//   idx_o   : binary index of the set bit (meaningful only when valid_o)
//   valid_o : exactly one bit of gnt_i is set
//   multi_o : more than one bit of gnt_i is set
// ----------------------------------------------------------------------------
module pixel_gnt_encoder #(
   parameter int N  = 256,
   parameter int AW = 8
) (
   input  logic [N-1:0]  gnt_i,
   output logic [AW-1:0] idx_o,
   output logic          valid_o,
   output logic          multi_o
);

   logic seen_one;

   // NOTE: every variable gets a default before the loop so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      idx_o    = '0;
      seen_one = 1'b0;
      multi_o  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (gnt_i[i]) begin
            if (seen_one) multi_o = 1'b1;
            seen_one = 1'b1;
            // OR-ing indices is exact for one-hot input; garbage otherwise,
            // which is fine because valid_o is then low.
            idx_o = idx_o | AW'(i);
         end
      end
   end

   assign valid_o = seen_one & ~multi_o;

endmodule

// File: rtl/pixel_event_requester.sv
// ----------------------------------------------------------------------------
// pixel_event_requester
// Accumulates per-pixel event pulses into saturating counters, requests
// arbitration for every pixel with pending events, and on a grant emits an
// {address, count} packet through a single-entry valid/ready output slot.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   event_i       : per-pixel event pulse (one event per bit per cycle)
//   req_o         : bit k high while pixel k has a non-zero count
//   gnt_i         : grant from arbiter, expected one-hot or zero
//   pkt_valid_o / pkt_ready_i / pkt_addr_o / pkt_count_o : readout stream
//   overflow_o    : sticky, an event was dropped at a saturated counter
//   gnt_err_o     : one-cycle pulse after a multi-hot grant
// ----------------------------------------------------------------------------
module pixel_event_requester
   import pixel_req_pkg::*;
#(
   parameter int NUM_REQUESTS = 256,
   parameter int CNT_W        = 4,
   parameter int ADDR_W       = addr_w(NUM_REQUESTS)
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [NUM_REQUESTS-1:0] event_i,
   output logic [NUM_REQUESTS-1:0] req_o,
   input  logic [NUM_REQUESTS-1:0] gnt_i,
   output logic                    pkt_valid_o,
   input  logic                    pkt_ready_i,
   output logic [ADDR_W-1:0]       pkt_addr_o,
   output logic [CNT_W-1:0]        pkt_count_o,
   output logic                    overflow_o,
   output logic                    gnt_err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_REQUESTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                               pkt_valid_q, pkt_valid_d;
   logic [ADDR_W-1:0]                  pkt_addr_q, pkt_addr_d;
   logic [CNT_W-1:0]                   pkt_count_q, pkt_count_d;
   logic                               overflow_q, overflow_d;
   logic                               gnt_err_q, gnt_err_d;

   logic [ADDR_W-1:0] gnt_idx;
   logic              gnt_valid;
   logic              gnt_multi;
   logic              slot_free;
   logic              capture;

   pixel_gnt_encoder #(
      .N  (NUM_REQUESTS),
      .AW (ADDR_W)
   ) u_gnt_encoder (
      .gnt_i   (gnt_i),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid),
      .multi_o (gnt_multi)
   );

   // Single output register stage; a transfer frees it in the same cycle.
   assign slot_free = !pkt_valid_q || pkt_ready_i;
   // Grants on idle pixels (e.g. lingering after a clear) fall through here.
   assign capture   = gnt_valid && (cnt_q[gnt_idx] != '0) && slot_free;

   always_comb begin
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      for (int k = 0; k < NUM_REQUESTS; k++) begin
         if (capture && (gnt_idx == ADDR_W'(k))) begin
            // The counter is handed off; a coinciding event starts the next
            // batch instead of being lost.
            cnt_d[k] = CNT_W'(event_i[k]);
         end else if (event_i[k]) begin
            if (cnt_q[k] == CNT_MAX) overflow_d = 1'b1;
            else                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      pkt_valid_d = pkt_valid_q;
      pkt_addr_d  = pkt_addr_q;
      pkt_count_d = pkt_count_q;
      if (capture) begin
         pkt_valid_d = 1'b1;
         pkt_addr_d  = gnt_idx;
         pkt_count_d = cnt_q[gnt_idx];
      end else if (pkt_ready_i) begin
         pkt_valid_d = 1'b0;
      end
      gnt_err_d = gnt_multi;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         // NOTE: the counter array is reset explicitly: pending counts must
         // be discarded on reset, so it cannot be left as uninitialised RAM.
         cnt_q       <= '0;
         pkt_valid_q <= 1'b0;
         pkt_addr_q  <= '0;
         pkt_count_q <= '0;
         overflow_q  <= 1'b0;
         gnt_err_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_addr_q  <= pkt_addr_d;
         pkt_count_q <= pkt_count_d;
         overflow_q  <= overflow_d;
         gnt_err_q   <= gnt_err_d;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REQUESTS; k++) req_o[k] = |cnt_q[k];
   end

   assign pkt_valid_o = pkt_valid_q;
   assign pkt_addr_o  = pkt_addr_q;
   assign pkt_count_o = pkt_count_q;
   assign overflow_o  = overflow_q;
   assign gnt_err_o   = gnt_err_q;

endmodule

// File: tb/tb_pixel_event_requester.sv
// ----------------------------------------------------------------------------
// tb_pixel_event_requester
// Directed bench: stimulus pushes expected packets into a queue, a monitor
// pops and compares on every stream transfer; status outputs are checked
// directly against hand-computed values.
// ----------------------------------------------------------------------------
module tb_pixel_event_requester;
   import pixel_req_pkg::*;

   localparam int N  = NUM_REQUESTS_DEF;
   localparam int CW = CNT_W_DEF;
   localparam int AW = ADDR_W_DEF;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [N-1:0]  event_i;
   logic [N-1:0]  req_o;
   logic [N-1:0]  gnt_i;
   logic          pkt_valid_o;
   logic          pkt_ready_i;
   logic [AW-1:0] pkt_addr_o;
   logic [CW-1:0] pkt_count_o;
   logic          overflow_o;
   logic          gnt_err_o;

   int checks = 0;
   int errors = 0;
   pixel_pkt_t exp_q[$];

   always #5 clk_i = ~clk_i;

   pixel_event_requester #(
      .NUM_REQUESTS (N),
      .CNT_W        (CW)
   ) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .event_i     (event_i),
      .req_o       (req_o),
      .gnt_i       (gnt_i),
      .pkt_valid_o (pkt_valid_o),
      .pkt_ready_i (pkt_ready_i),
      .pkt_addr_o  (pkt_addr_o),
      .pkt_count_o (pkt_count_o),
      .overflow_o  (overflow_o),
      .gnt_err_o   (gnt_err_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [N-1:0] bit_of(input int k);
      logic [N-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic expect_pkt(input int addr, input int count);
      pixel_pkt_t p;
      p.addr  = AW'(addr);
      p.count = CW'(count);
      exp_q.push_back(p);
   endtask

   // Monitor: one comparison per transfer, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (rstn_i && pkt_valid_o && pkt_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt: got addr %0d count %0d expected none",
                     pkt_addr_o, pkt_count_o);
         end else begin
            check("pkt", {pkt_addr_o, pkt_count_o}, exp_q.pop_front());
         end
      end
   end

   initial begin
      rstn_i      = 1'b0;
      event_i     = '0;
      gnt_i       = '0;
      pkt_ready_i = 1'b1;
      #12;
      check("rst_req",      |req_o,      0);
      check("rst_valid",    pkt_valid_o, 0);
      check("rst_overflow", overflow_o,  0);
      check("rst_gnt_err",  gnt_err_o,   0);
      step();
      rstn_i = 1'b1;
      step();

      // 1: three events on pixel 5, then grant
      event_i = bit_of(5);
      repeat (3) step();
      event_i = '0;
      check("t1_req5_set", req_o[5], 1);
      gnt_i = bit_of(5);
      expect_pkt(5, 3);
      step();
      gnt_i = '0;
      check("t1_valid", pkt_valid_o, 1);
      check("t1_req5_clr", req_o[5], 0);
      step();
      check("t1_valid_fall", pkt_valid_o, 0);

      // 2: saturation and sticky overflow on pixel 0
      event_i = bit_of(0);
      repeat (20) step();
      event_i = '0;
      check("t2_overflow", overflow_o, 1);
      check("t2_req0", req_o[0], 1);
      gnt_i = bit_of(0);
      expect_pkt(0, 15);
      step();
      gnt_i = '0;
      step();
      check("t2_overflow_sticky", overflow_o, 1);
      check("t2_req0_clr", req_o[0], 0);

      // 3: event coinciding with grant on pixel 7
      event_i = bit_of(7);
      repeat (2) step();
      gnt_i = bit_of(7);
      expect_pkt(7, 2);
      step();
      gnt_i   = '0;
      event_i = '0;
      check("t3_req7_kept", req_o[7], 1);
      step();
      gnt_i = bit_of(7);
      expect_pkt(7, 1);
      step();
      gnt_i = '0;
      step();
      check("t3_req7_clr", req_o[7], 0);

      // 4: back-pressure blocks a grant, then pop-and-push
      event_i = bit_of(1) | bit_of(2);
      step();
      event_i     = '0;
      pkt_ready_i = 1'b0;
      gnt_i       = bit_of(1);
      expect_pkt(1, 1);
      step();
      gnt_i = bit_of(2);
      step();
      gnt_i = '0;
      check("t4_hold_valid", pkt_valid_o, 1);
      check("t4_hold_addr",  pkt_addr_o,  1);
      check("t4_hold_count", pkt_count_o, 1);
      check("t4_req2_kept",  req_o[2],    1);
      pkt_ready_i = 1'b1;
      gnt_i       = bit_of(2);
      expect_pkt(2, 1);
      step();
      gnt_i = '0;
      check("t4_b2b_valid", pkt_valid_o, 1);
      check("t4_b2b_addr",  pkt_addr_o,  2);
      step();
      check("t4_drained", pkt_valid_o, 0);

      // 5: multi-hot grant
      event_i = bit_of(3) | bit_of(4);
      step();
      event_i = '0;
      gnt_i   = bit_of(3) | bit_of(4);
      step();
      gnt_i = '0;
      check("t5_gnt_err", gnt_err_o,   1);
      check("t5_no_pkt",  pkt_valid_o, 0);
      check("t5_req3",    req_o[3],    1);
      check("t5_req4",    req_o[4],    1);
      step();
      check("t5_gnt_err_pulse", gnt_err_o, 0);
      gnt_i = bit_of(3);
      expect_pkt(3, 1);
      step();
      gnt_i = bit_of(4);
      expect_pkt(4, 1);
      step();
      gnt_i = '0;
      step();

      // 6: lingering grant yields one packet; reset mid-packet
      event_i = bit_of(9);
      step();
      event_i = '0;
      gnt_i   = bit_of(9);
      expect_pkt(9, 1);
      repeat (3) step();
      gnt_i = '0;
      step();
      check("t6_single_pkt", pkt_valid_o, 0);
      event_i = bit_of(9) | bit_of(10);
      step();
      event_i     = '0;
      pkt_ready_i = 1'b0;
      gnt_i       = bit_of(9);
      step();
      gnt_i = '0;
      check("t6_valid_before_rst", pkt_valid_o, 1);
      check("t6_req10_before_rst", req_o[10],   1);
      #2;
      rstn_i = 1'b0;
      #1;
      check("t6_rst_valid",    pkt_valid_o, 0);
      check("t6_rst_req",      |req_o,      0);
      check("t6_rst_addr",     pkt_addr_o,  0);
      check("t6_rst_count",    pkt_count_o, 0);
      check("t6_rst_overflow", overflow_o,  0);
      step();
      rstn_i      = 1'b1;
      pkt_ready_i = 1'b1;
      step();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
